// File: rtl/alu_seq_pkg.sv
// Shared opcode values and FSM state type for the sequential ALU.
package alu_seq_pkg;

    localparam int OP_NOP = 0;
    localparam int OP_ADD = 1;
    localparam int OP_ADC = 2;
    localparam int OP_SUB = 3;
    localparam int OP_AND = 4;
    localparam int OP_XOR = 5;
    localparam int OP_LDA = 6;
    localparam int OP_SHL = 7;
    localparam int OP_SHR = 8;
    localparam int OP_MUL = 9;
    localparam int OP_CLR = 10;

    typedef enum logic {
        IDLE,
        MUL
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per clock, WIDTH clocks per multiply.
module alu_mul_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic [2*WIDTH-1:0] prod,
    output logic               fin
);

    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] prod_step;

    // prod exposes the product including the current step, so the final
    // partial product lands in the accumulator on the same edge as fin.
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign fin       = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign busy      = busy_q;
    assign prod      = prod_step;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
        end else if (busy_q) begin
            prod_d   = prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (fin) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        prod_q   <= prod_d;
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU owning the accumulator and zero/carry flags, with a
// valid/ready operation interface and a multi-cycle multiply.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] acc,
    output logic             zero,
    output logic             carry,
    output logic             done
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_fin;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     add_res, adc_res, sub_res;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (int'(opcode) == OP_MUL);

    // Bit WIDTH of each result is the carry out (or borrow for subtract).
    assign add_res = {1'b0, acc_q} + {1'b0, data};
    assign adc_res = add_res + (WIDTH + 1)'(carry_q);
    assign sub_res = {1'b0, acc_q} - {1'b0, data};

    alu_mul_seq #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (acc_q),
        .b     (data),
        .busy  (mul_busy),
        .prod  (mul_prod),
        .fin   (mul_fin)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        if (accept) begin
            done_d = 1'b1;
            case (int'(opcode))
                OP_ADD: {carry_d, acc_d} = add_res;
                OP_ADC: {carry_d, acc_d} = adc_res;
                OP_SUB: {carry_d, acc_d} = sub_res;
                OP_AND: acc_d = acc_q & data;
                OP_XOR: acc_d = acc_q ^ data;
                OP_LDA: acc_d = data;
                OP_SHL: {carry_d, acc_d} = {acc_q, 1'b0};
                OP_SHR: {acc_d, carry_d} = {1'b0, acc_q};
                OP_MUL: begin
                    state_d = MUL;
                    done_d  = 1'b0;
                end
                OP_CLR: begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                end
                default: ;
            endcase
        end else if (state_q == MUL && mul_busy && mul_fin) begin
            acc_d   = mul_prod[WIDTH-1:0];
            carry_d = |mul_prod[2*WIDTH-1:WIDTH];
            state_d = IDLE;
            done_d  = 1'b1;
        end
        zero_d = (acc_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign acc   = acc_q;
    assign zero  = zero_q;
    assign carry = carry_q;
    assign done  = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

    localparam int WIDTH = 8;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       opcode = '0;
    logic [WIDTH-1:0] data = '0;
    logic [WIDTH-1:0] acc;
    logic             zero;
    logic             carry;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: plain integers plus a countdown for multiply.
    int m_acc = 0;
    int m_carry = 0;
    int m_done = 0;
    int m_busy = 0;
    int m_pend = 0;

    alu_seq #(.WIDTH(WIDTH), .OPW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .data     (data),
        .acc      (acc),
        .zero     (zero),
        .carry    (carry),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic v, input int op, input int d, input logic r);
        int t;
        if (r) begin
            m_acc = 0; m_carry = 0; m_done = 0; m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            m_done = 0;
            if (m_busy == 0) begin
                m_acc   = m_pend & MASK;
                m_carry = ((m_pend >> WIDTH) != 0) ? 1 : 0;
                m_done  = 1;
            end
        end else if (v) begin
            m_done = 1;
            case (op)
                1: begin t = m_acc + d; m_acc = t & MASK; m_carry = (t >> WIDTH) & 1; end
                2: begin t = m_acc + d + m_carry; m_acc = t & MASK; m_carry = (t >> WIDTH) & 1; end
                3: begin m_carry = (m_acc < d) ? 1 : 0; m_acc = (m_acc - d) & MASK; end
                4: m_acc = m_acc & d;
                5: m_acc = m_acc ^ d;
                6: m_acc = d;
                7: begin m_carry = (m_acc >> (WIDTH - 1)) & 1; m_acc = (m_acc << 1) & MASK; end
                8: begin m_carry = m_acc & 1; m_acc = m_acc >> 1; end
                9: begin m_pend = m_acc * d; m_busy = WIDTH; m_done = 0; end
                10: begin m_acc = 0; m_carry = 0; end
                default: ;
            endcase
        end else begin
            m_done = 0;
        end
    endtask

    task automatic step(input logic v, input int op, input int d, input logic r);
        @(negedge clk);
        in_valid = v;
        opcode   = 4'(op);
        data     = WIDTH'(d);
        rst      = r;
        @(posedge clk);
        model_edge(v, op, d, r);
        #1;
        chk("acc",      32'(acc),      32'(m_acc));
        chk("zero",     32'(zero),     32'(m_acc == 0));
        chk("carry",    32'(carry),    32'(m_carry));
        chk("done",     32'(done),     32'(m_done));
        chk("in_ready", 32'(in_ready), 32'(m_busy == 0));
    endtask

    initial begin
        int low_cnt;
        int done_cnt;

        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 6, 8'h77, 1'b1);
        chk("rst_acc", 32'(acc), 32'h00);
        chk("rst_zero", 32'(zero), 32'h1);

        step(1'b1, 6, 8'h33, 1'b0);
        step(1'b1, 1, 8'hAA, 1'b0);
        chk("add_dd", 32'(acc), 32'hDD);
        step(1'b1, 1, 8'h30, 1'b0);
        chk("add_0d_c", 32'({carry, acc}), 32'h10D);
        step(1'b1, 2, 8'h01, 1'b0);
        chk("adc_0f", 32'({carry, acc}), 32'h00F);
        step(1'b1, 3, 8'h0F, 1'b0);
        chk("sub_zero", 32'(zero), 32'h1);
        step(1'b1, 3, 8'h10, 1'b0);
        chk("sub_borrow", 32'({carry, acc}), 32'h1F0);
        step(1'b1, 7, 0, 1'b0);
        chk("shl", 32'({carry, acc}), 32'h1E0);
        step(1'b1, 8, 0, 1'b0);
        chk("shr", 32'({carry, acc}), 32'h070);
        step(1'b1, 10, 8'hFF, 1'b0);
        chk("clr", 32'({carry, zero, acc}), 32'h100);

        // Multiply with an ignored request held during the busy window.
        step(1'b1, 6, 8'h12, 1'b0);
        step(1'b1, 9, 8'h0B, 1'b0);
        low_cnt  = (in_ready == 1'b0) ? 1 : 0;
        done_cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b1, 1, 8'h01, 1'b0);
            if (in_ready == 1'b0) low_cnt++;
            if (done == 1'b1) done_cnt++;
        end
        chk("mul_ready_low", 32'(low_cnt), 32'(WIDTH));
        chk("mul_c6", 32'({carry, acc}), 32'h0C6);
        step(1'b0, 0, 0, 1'b0);
        chk("mul_done_once", 32'(done_cnt), 32'h1);

        step(1'b1, 6, 8'h20, 1'b0);
        step(1'b1, 9, 8'h10, 1'b0);
        for (int i = 0; i < WIDTH; i++) step(1'b0, 0, 0, 1'b0);
        chk("mul_ovf", 32'({carry, zero, acc}), 32'h300);

        // Reset landing on the third busy cycle aborts the multiply.
        step(1'b1, 6, 8'h12, 1'b0);
        step(1'b1, 9, 8'h0B, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        chk("abort_ready", 32'(in_ready), 32'h1);
        done_cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b0, 0, 0, 1'b0);
            if (done == 1'b1) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'h0);
        chk("abort_acc", 32'(acc), 32'h00);

        // Undefined opcode leaves state alone but still completes.
        step(1'b1, 6, 8'h80, 1'b0);
        step(1'b1, 7, 0, 1'b0);
        step(1'b1, 6, 8'h55, 1'b0);
        step(1'b1, 15, 8'hFF, 1'b0);
        chk("op_f", 32'({done, carry, zero, acc}), 32'h655);
        step(1'b0, 0, 0, 1'b0);
        chk("op_f_done_once", 32'(done), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, MASK)), 1'($urandom_range(0, 79) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the CPU's 8-bit combinational ALU.
- Owns the accumulator register and its zero/carry flags.
- Accepts one operation per valid/ready handshake; extends the op set with carry, subtract, shifts and a multi-cycle shift-add multiply.
- Sits between the instruction controller (which issues opcode/data) and the datapath that reads acc/zero.

Parameters:
- WIDTH, 8, datapath/accumulator width in bits (>=2).
- OPW, 4, opcode width.
- CW, $clog2(WIDTH)+1, multiply step-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; high iff state==IDLE (combinational from state only).
- opcode  input  OPW  operation, sampled on accept.
- data  input  WIDTH  operand B, sampled on accept.
- acc  output  WIDTH  accumulator register.
- zero  output  1  registered, equals (acc==0) at all times after reset.
- carry  output  1  carry/borrow flag register.
- done  output  1  one-cycle pulse, cycle after acc/flags update.

Behaviour:
- Decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values: acc=0, zero=1, carry=0, done=0, state=IDLE (so in_ready=1).
- Accept = in_valid & in_ready at a rising edge. in_valid while not ready is ignored and not queued.
- Opcodes:
  - 0 NOP: no change.
  - 1 ADD: {carry,acc}=acc+data.
  - 2 ADC: {carry,acc}=acc+data+carry.
  - 3 SUB: acc=acc-data; carry=borrow (1 iff acc<data unsigned).
  - 4 AND: acc=acc&data.
  - 5 XOR: acc=acc^data.
  - 6 LDA: acc=data.
  - 7 SHL: {carry,acc}={acc,0}.
  - 8 SHR: {acc,carry}={0,acc}.
  - 9 MUL: multi-cycle, see below.
  - 10 CLR: acc=0, carry=0.
  - 11-15: treated as NOP.
- Carry is unchanged by AND, XOR, LDA and NOP.
- Single-cycle ops: acc/carry/zero update on the accept edge; done=1 for the following cycle; in_ready stays 1, allowing back-to-back accepts every cycle.
- MUL FSM, IDLE->MUL->IDLE:
  - On accept, latch multiplicand=acc and multiplier=data; clear the 2*WIDTH product; cnt=0.
  - Each edge in MUL: if multiplier LSB is set, add the shifted multiplicand to the product; shift; cnt++.
  - On the edge with cnt==WIDTH-1: acc=product[WIDTH-1:0], carry=|product[2W-1:W], zero updated, return to IDLE, done pulses next cycle.
  - in_ready is low for exactly WIDTH cycles after the accept edge. Total latency is WIDTH edges.
- Arithmetic is unsigned, modulo 2^WIDTH; carry holds bit WIDTH.
- zero is recomputed from the next acc value on every edge that writes acc.
- rst during MUL: abort, apply reset values, no done pulse.
- rst with in_valid high: reset wins, op not accepted.
- done never asserts for an unaccepted request.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_NOP..OP_CLR;
  - the state enum IDLE/MUL.
- Sub-module alu_mul_seq (shift-add multiplier):
  - inputs: clk, rst, start, a, b;
  - outputs: busy, prod[2*WIDTH-1:0], fin.
- alu_seq top contains the handshake, single-cycle ops and the flag registers.

Test Plan:
- Reset: assert rst 2 cycles -> acc=00, zero=1, carry=0, in_ready=1, done=0.
- LDA 33, ADD AA -> acc=DD, zero=0, carry=0. Then ADD 30 -> acc=0D, carry=1. Then ADC 01 -> acc=0F, carry=0. Each followed by a 1-cycle done pulse; back-to-back accepts succeed.
- SUB with acc=0F: SUB 0F -> acc=00, zero=1, carry=0. Then SUB 10 -> acc=F0, carry=1. SHL with acc=F0 -> acc=E0, carry=1. SHR -> acc=70, carry=0. CLR -> acc=00, carry=0, zero=1.
- MUL:
  - LDA 12, MUL 0B -> in_ready low exactly 8 cycles; then acc=C6, carry=0, done pulse.
  - LDA 20, MUL 10 -> acc=00, zero=1, carry=1.
- ADD 01 presented while MUL is busy -> ignored, final acc=C6. Separately, rst on the 3rd busy cycle -> acc=00, in_ready=1 next cycle, no done.
- Opcode F with data=FF, acc=55, carry=1 -> acc=55, carry=1, zero=0 unchanged, done pulses once.
